// File: rtl/vrb_ram_slave.sv
// Single-port data RAM responder on the vrb bus.
// Byte-masked writes, combinational reads, in-order responses through a small FIFO.
module vrb_ram_slave #(
  parameter int unsigned     AW        = 32,
  parameter int unsigned     DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h0001_0000,
  parameter int unsigned     DEPTH     = 1024,
  parameter int unsigned     RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vrb_cmd_valid,
  output logic              o_vrb_cmd_ready,
  input  logic [AW-1:0]     i_vrb_cmd_addr,
  input  logic              i_vrb_cmd_read,
  input  logic [DW-1:0]     i_vrb_cmd_wdata,
  input  logic [DW/8-1:0]   i_vrb_cmd_wmask,
  output logic              o_vrb_rsp_valid,
  input  logic              i_vrb_rsp_ready,
  output logic              o_vrb_rsp_err,
  output logic [DW-1:0]     o_vrb_rsp_rdata
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LB = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] RANGE = AW'(DEPTH * NB);

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] fifo_rdata [RSP_DEPTH];
  logic          fifo_err   [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic [AW-1:0] off;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [DW-1:0] rd_word;
  logic          push;
  logic          pop;

  // Offset wraps modulo 2^AW, so addresses below BASE_ADDR land far out of range.
  assign off      = i_vrb_cmd_addr - BASE_ADDR;
  assign in_range = off < RANGE;
  assign idx      = off[LB +: IW];
  assign rd_word  = mem[idx];

  assign o_vrb_cmd_ready = fifo_cnt < CW'(RSP_DEPTH);
  assign o_vrb_rsp_valid = fifo_cnt != '0;
  assign o_vrb_rsp_err   = fifo_err[rd_ptr];
  assign o_vrb_rsp_rdata = fifo_rdata[rd_ptr];

  assign push = i_vrb_cmd_valid & o_vrb_cmd_ready;
  assign pop  = o_vrb_rsp_valid & i_vrb_rsp_ready;

  // RAM storage is deliberately left out of reset so data survives a bus reset.
  always_ff @(posedge clk) begin
    if (push && !i_vrb_cmd_read && in_range) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (i_vrb_cmd_wmask[b]) begin
          mem[idx][8*b +: 8] <= i_vrb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_rdata[i] <= '0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_err[wr_ptr]   <= !in_range;
        fifo_rdata[wr_ptr] <= (i_vrb_cmd_read && in_range) ? rd_word : '0;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_vrb_ram_slave.sv
// Directed bench for vrb_ram_slave: vector table for single accesses,
// hand-written sequences for back-to-back, backpressure, streaming and reset.
module tb_vrb_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  vrb_ram_slave dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vrb_cmd_valid (cmd_valid),
    .o_vrb_cmd_ready (cmd_ready),
    .i_vrb_cmd_addr  (cmd_addr),
    .i_vrb_cmd_read  (cmd_read),
    .i_vrb_cmd_wdata (cmd_wdata),
    .i_vrb_cmd_wmask (cmd_wmask),
    .o_vrb_rsp_valid (rsp_valid),
    .i_vrb_rsp_ready (rsp_ready),
    .o_vrb_rsp_err   (rsp_err),
    .o_vrb_rsp_rdata (rsp_rdata)
  );

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one command, waits (bounded) for acceptance, returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wmask = wmask;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL accept_timeout: got ready=0, expected ready=1 within 20 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic checkRsp(input string name, input logic exp_err, input logic [31:0] exp_rdata);
    checkOutput({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    checkOutput({name, "_err"},   {31'b0, rsp_err},   {31'b0, exp_err});
    checkOutput({name, "_rdata"}, rsp_rdata,          exp_rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0001_0000, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0001_0000, 32'h00AA_0000, 4'h4, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h0001_0000, 32'h0,         4'h0, 1'b0, 32'hDEAA_BEEF};
    vecs[4]  = '{1'b0, 32'h0001_0004, 32'h1122_3344, 4'hF, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0001_0004, 32'hAABB_CCDD, 4'h3, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h0001_0004, 32'h0,         4'h0, 1'b0, 32'h1122_CCDD};
    vecs[7]  = '{1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h0001_0003, 32'h0,         4'h0, 1'b0, 32'hDEAA_BEEF};
    vecs[9]  = '{1'b0, 32'h0001_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0001_0FFC, 32'h7700_0000, 4'h8, 1'b0, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h0001_0FFC, 32'h0,         4'h0, 1'b0, 32'h77FE_F00D};
    vecs[12] = '{1'b1, 32'h0000_FFFC, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b1, 32'h0001_1000, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[14] = '{1'b0, 32'h0001_1000, 32'h5555_5555, 4'hF, 1'b1, 32'h0000_0000};
    vecs[15] = '{1'b1, 32'h0001_0000, 32'h0,         4'h0, 1'b0, 32'hDEAA_BEEF};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b1;
    #12;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("reset_rsp_err",   {31'b0, rsp_err},   32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      checkRsp($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Write then read on consecutive edges: read must see the fresh data.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h0001_0008;
    cmd_wdata = 32'hA5A5_0F0F; cmd_wmask = 4'hF;
    checkOutput("b2b_ready0", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    checkRsp("b2b_wr", 1'b0, 32'h0);
    cmd_read = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkRsp("b2b_rd", 1'b0, 32'hA5A5_0F0F);
    @(negedge clk);
    checkOutput("b2b_drained", {31'b0, rsp_valid}, 32'd0);

    // Backpressure: FIFO fills after two reads, third waits for the first pop.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0001_0000;
    checkOutput("bp_ready_a", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_addr = 32'h0001_0004;
    checkOutput("bp_ready_b", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_addr = 32'h0001_0FFC;
    checkOutput("bp_full_c0", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    checkOutput("bp_full_c1", {31'b0, cmd_ready}, 32'd0);
    checkRsp("bp_head_hold", 1'b0, 32'hDEAA_BEEF);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_after_pop", {31'b0, cmd_ready}, 32'd1);
    checkRsp("bp_rsp_b", 1'b0, 32'h1122_CCDD);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkRsp("bp_rsp_c", 1'b0, 32'h77FE_F00D);
    @(negedge clk);
    checkOutput("bp_drained", {31'b0, rsp_valid}, 32'd0);

    // Streaming: fill eight words, then read them one per cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 32'h0001_0020 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'hF);
      checkRsp($sformatf("st_wr%0d", k), 1'b0, 32'h0);
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0001_0020 + 32'(4 * k);
      checkOutput($sformatf("st_ready%0d", k), {31'b0, cmd_ready}, 32'd1);
      @(negedge clk);
      checkRsp($sformatf("st_rd%0d", k), 1'b0, 32'h1111_1111 * 32'(k + 1));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("st_drained", {31'b0, rsp_valid}, 32'd0);

    // Reset with two responses queued: flushed at once, RAM contents survive.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0001_0000;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("rst_pre_full",  {31'b0, cmd_ready}, 32'd0);
    checkOutput("rst_pre_valid", {31'b0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_mid_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 32'h0001_0008, 32'h0, 4'h0);
    checkRsp("rst_ram_kept", 1'b0, 32'hA5A5_0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
